// File: rtl/app_pio_spi_bridge.sv
// rtl/app_pio_spi_bridge.sv - PIO toggle-handshake to mode-0 SPI master bridge
// One 24-bit SPI transfer per request toggle; response and ack toggle returned on the input PIO.
module app_pio_spi_bridge #(
  parameter int NUM_CS   = 8,
  parameter int CLK_DIV  = 5,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4
) (
  input  logic              clk50_clk,
  input  logic              reset_reset_n,
  input  logic [31:0]       app_pio_out_port,
  output logic [31:0]       app_pio_in_port,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_ERR,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [3:0]  NUM_CS_W   = 4'(NUM_CS);
  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [4:0]  bit_cnt;
  logic        high_phase;
  logic [2:0]  sel_q;
  logic [23:0] tx_sr;
  logic [23:0] rx_sr;
  logic        miso_s1;
  logic        miso_s2;
  logic        ack;
  logic        busy;
  logic [2:0]  sel_echo;
  logic        sel_err;
  logic [23:0] resp;
  logic [NUM_CS-1:0] cs_hot;
  logic        unused_pio;

  assign unused_pio = ^app_pio_out_port[27:24];

  assign app_pio_in_port = {ack, busy, sel_echo, sel_err, 2'b00, resp};

  always_comb begin
    cs_hot = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      cs_hot[i] = (sel_q == 3'(i));
    end
  end

  always_ff @(posedge clk50_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      high_phase <= 1'b0;
      sel_q      <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      miso_s1    <= 1'b0;
      miso_s2    <= 1'b0;
      ack        <= 1'b0;
      busy       <= 1'b0;
      sel_echo   <= '0;
      sel_err    <= 1'b0;
      resp       <= '0;
      spi_sclk   <= 1'b0;
      spi_mosi   <= 1'b0;
      spi_cs_n   <= '1;
    end else begin
      miso_s1 <= spi_miso;
      miso_s2 <= miso_s1;
      case (state)
        S_IDLE: begin
          if (app_pio_out_port[31] != ack) begin
            sel_q <= app_pio_out_port[30:28];
            tx_sr <= app_pio_out_port[23:0];
            busy  <= 1'b1;
            state <= S_ARM;
          end
        end
        // Decode cycle between the sampling edge and chip-select/error action.
        S_ARM: begin
          if ({1'b0, sel_q} >= NUM_CS_W) begin
            state <= S_ERR;
          end else begin
            spi_cs_n <= ~cs_hot;
            spi_mosi <= tx_sr[23];
            cnt      <= '0;
            state    <= S_SETUP;
          end
        end
        S_ERR: begin
          sel_err  <= 1'b1;
          sel_echo <= sel_q;
          ack      <= ~ack;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt        <= '0;
            bit_cnt    <= '0;
            high_phase <= 1'b0;
            state      <= S_SHIFT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_SHIFT: begin
          if (cnt != DIV_LAST) begin
            cnt <= cnt + 16'd1;
          end else if (!high_phase) begin
            cnt        <= '0;
            high_phase <= 1'b1;
            spi_sclk   <= 1'b1;
          end else begin
            // Last high cycle: capture MISO, drop SCLK and present the next MOSI bit.
            cnt        <= '0;
            high_phase <= 1'b0;
            spi_sclk   <= 1'b0;
            rx_sr      <= {rx_sr[22:0], miso_s2};
            tx_sr      <= {tx_sr[22:0], 1'b0};
            spi_mosi   <= tx_sr[22];
            if (bit_cnt == 5'd23) begin
              state <= S_HOLD;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt      <= '0;
            spi_cs_n <= '1;
            state    <= S_DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DONE: begin
          resp     <= rx_sr;
          sel_echo <= sel_q;
          sel_err  <= 1'b0;
          ack      <= ~ack;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_app_pio_spi_bridge.sv
// tb/tb_app_pio_spi_bridge.sv - self-checking bench for app_pio_spi_bridge
// Table-driven transfers plus hand-written error, reset and double-toggle sequences.
module tb_app_pio_spi_bridge;

  logic        clk;
  logic        rst_n;
  logic [31:0] out1, in1;
  logic        sclk1, mosi1, miso1;
  logic [7:0]  cs1;
  logic [31:0] out4, in4;
  logic        sclk4, mosi4;
  logic [3:0]  cs4;

  logic        use_slave;
  logic [23:0] slave_data;
  logic [23:0] slave_sr;
  logic        sclk1_d;

  int cyc;
  int n_cmp;
  int n_bad;

  int          rise_cnt1, last_rise1, prev_rise1;
  logic [23:0] mosi_cap1;
  logic [7:0]  cs_at_rise1;
  int          rise_cnt4, cs4_low;
  logic [23:0] mosi_cap4;

  typedef struct {
    logic        toggle;
    logic [2:0]  sel;
    logic [23:0] payload;
    logic        use_slave;
    logic [23:0] slave_data;
    logic [31:0] exp_in;
    logic [7:0]  exp_cs;
  } vec_t;

  vec_t vecs[4];

  app_pio_spi_bridge dut (
    .clk50_clk        (clk),
    .reset_reset_n    (rst_n),
    .app_pio_out_port (out1),
    .app_pio_in_port  (in1),
    .spi_sclk         (sclk1),
    .spi_mosi         (mosi1),
    .spi_miso         (miso1),
    .spi_cs_n         (cs1)
  );

  app_pio_spi_bridge #(.NUM_CS(4)) dut4 (
    .clk50_clk        (clk),
    .reset_reset_n    (rst_n),
    .app_pio_out_port (out4),
    .app_pio_in_port  (in4),
    .spi_sclk         (sclk4),
    .spi_mosi         (mosi4),
    .spi_miso         (mosi4),
    .spi_cs_n         (cs4)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign miso1 = use_slave ? slave_sr[23] : mosi1;

  // Mode-0 slave: loads on idle, shifts half a cycle after each SCLK fall.
  initial begin
    slave_sr = '0;
    sclk1_d  = 1'b0;
  end
  always @(negedge clk) begin
    sclk1_d <= sclk1;
    if (&cs1) slave_sr <= slave_data;
    else if (sclk1_d && !sclk1) slave_sr <= {slave_sr[22:0], 1'b0};
  end

  initial begin
    rise_cnt1 = 0; last_rise1 = 0; prev_rise1 = 0; mosi_cap1 = '0; cs_at_rise1 = '0;
  end
  always @(posedge sclk1) begin
    prev_rise1  = last_rise1;
    last_rise1  = cyc;
    cs_at_rise1 = cs1;
    mosi_cap1   = {mosi_cap1[22:0], mosi1};
    rise_cnt1   = rise_cnt1 + 1;
  end

  initial begin
    rise_cnt4 = 0; mosi_cap4 = '0;
  end
  always @(posedge sclk4) begin
    mosi_cap4 = {mosi_cap4[22:0], mosi4};
    rise_cnt4 = rise_cnt4 + 1;
  end

  initial cs4_low = 0;
  always @(negedge clk) if (cs4 != 4'hF) cs4_low = cs4_low + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ack(input logic old_ack, input bit on4, output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if ((on4 ? in4[31] : in1[31]) != old_ack) begin
        lat = k;
        break;
      end
      if (on4 ? in4[30] : in1[30]) bcnt++;
      @(posedge clk);
    end
  endtask

  int lat, bcnt, base, base_cs, k1, k2;
  logic old_ack, last_ack;
  logic [31:0] w1, w2;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vecs[0] = '{1'b1, 3'd2, 24'hA5C3F0, 1'b0, 24'h000000, 32'h90A5C3F0, 8'hFB};
    vecs[1] = '{1'b0, 3'd7, 24'h5A5A5A, 1'b1, 24'h123456, 32'h38123456, 8'h7F};
    vecs[2] = '{1'b1, 3'd0, 24'hFFFFFF, 1'b0, 24'h000000, 32'h80FFFFFF, 8'hFE};
    vecs[3] = '{1'b0, 3'd4, 24'h000001, 1'b1, 24'h800001, 32'h20800001, 8'hEF};

    rst_n = 1'b0; out1 = '0; out4 = '0; use_slave = 1'b0; slave_data = '0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("reset_in",   in1, 32'h0);
    check("reset_cs",   {24'h0, cs1}, 32'h0000_00FF);
    check("reset_sclk", {31'h0, sclk1}, 32'h0);
    check("reset_mosi", {31'h0, mosi1}, 32'h0);
    check("reset_in4",  in4, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      slave_data = vecs[v].slave_data;
      use_slave  = vecs[v].use_slave;
      @(negedge clk);
      base    = rise_cnt1;
      old_ack = in1[31];
      out1    = {vecs[v].toggle, vecs[v].sel, 4'h0, vecs[v].payload};
      @(posedge clk);
      wait_ack(old_ack, 1'b0, lat, bcnt);
      check($sformatf("v%0d_latency", v), lat, 250);
      check($sformatf("v%0d_busy_cycles", v), bcnt, 250);
      check($sformatf("v%0d_in_port", v), in1, vecs[v].exp_in);
      check($sformatf("v%0d_sclk_pulses", v), rise_cnt1 - base, 24);
      check($sformatf("v%0d_mosi_bits", v), {8'h0, mosi_cap1}, {8'h0, vecs[v].payload});
      check($sformatf("v%0d_cs_active", v), {24'h0, cs_at_rise1}, {24'h0, vecs[v].exp_cs});
      check($sformatf("v%0d_sclk_period", v), last_rise1 - prev_rise1, 10);
      check($sformatf("v%0d_idle_lines", v), {22'h0, mosi1, sclk1, cs1}, {22'h0, 2'b00, 8'hFF});
    end
    use_slave = 1'b0;

    // Select error on a 4-select instance, bracketed by valid transfers.
    @(negedge clk);
    base = rise_cnt4;
    out4 = {1'b1, 3'd1, 4'h0, 24'h3C3C3C};
    @(posedge clk);
    wait_ack(1'b0, 1'b1, lat, bcnt);
    check("sel4_ok_latency", lat, 250);
    check("sel4_ok_in", in4, 32'h883C3C3C);
    check("sel4_ok_mosi", {8'h0, mosi_cap4}, 32'h003C3C3C);
    @(negedge clk);
    base    = rise_cnt4;
    base_cs = cs4_low;
    out4    = {1'b0, 3'd5, 4'h0, 24'h111111};
    @(posedge clk);
    wait_ack(1'b1, 1'b1, lat, bcnt);
    check("err_latency", lat, 2);
    check("err_in", in4, 32'h2C3C3C3C);
    repeat (5) @(negedge clk);
    check("err_no_sclk", rise_cnt4 - base, 0);
    check("err_no_cs", cs4_low - base_cs, 0);
    out4 = {1'b1, 3'd3, 4'h0, 24'h0F0F0F};
    @(posedge clk);
    wait_ack(1'b0, 1'b1, lat, bcnt);
    check("err_clear_latency", lat, 250);
    check("err_clear_in", in4, 32'h980F0F0F);
    @(negedge clk);
    out4 = '0;

    // Reset in the middle of SHIFT, released with a pending request.
    base = rise_cnt1;
    out1 = {1'b1, 3'd3, 4'h0, 24'hABCDEF};
    @(posedge clk);
    for (int k = 0; k < 400 && (rise_cnt1 - base) < 11; k++) @(posedge clk);
    check("mid_reached_bit10", ((rise_cnt1 - base) >= 11) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_reset_cs", {24'h0, cs1}, 32'h0000_00FF);
    check("mid_reset_sclk", {31'h0, sclk1}, 32'h0);
    check("mid_reset_in", in1, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = rise_cnt1;
    @(posedge clk);
    wait_ack(1'b0, 1'b0, lat, bcnt);
    check("post_reset_latency", lat, 250);
    check("post_reset_in", in1, 32'h98ABCDEF);
    check("post_reset_pulses", rise_cnt1 - base, 24);

    // Double toggle while busy: second transfer uses the word current at the first ack.
    @(negedge clk);
    out1 = {1'b0, 3'd1, 4'h0, 24'h0000AA};
    last_ack = in1[31];
    k1 = -1; k2 = -1; w1 = '0; w2 = '0;
    @(posedge clk);
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (k == 95) out1 = {1'b1, 3'd6, 4'h0, 24'h555500};
      if (in1[31] != last_ack) begin
        last_ack = in1[31];
        if (k1 < 0) begin
          k1 = k; w1 = in1;
        end else begin
          k2 = k; w2 = in1;
          break;
        end
      end
      @(posedge clk);
    end
    check("dbl_first_ack", k1, 250);
    check("dbl_first_in", w1, 32'h080000AA);
    check("dbl_second_ack", k2, 501);
    check("dbl_second_in", w2, 32'hB0555500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
